// File: rtl/magnitude_comparator.sv
// Registered unsigned/signed magnitude comparator built from an MSB-first bit-cell cascade.
// Define COMPARATOR_SIGNED_EN to compare operands as two's complement.
module magnitude_comparator #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic             x,
    output logic             y,
    output logic             z
);

`ifdef COMPARATOR_SIGNED_EN
    localparam bit MSB_INV = 1'b1;
`else
    localparam bit MSB_INV = 1'b0;
`endif

    logic gt_c;
    logic eq_c;
    logic lt_c;

    // Cascade of per-bit cells from MSB to LSB; first differing bit decides.
    always_comb begin
        gt_c = 1'b0;
        eq_c = 1'b1;
        lt_c = 1'b0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (!gt_c && !lt_c) begin
                if (a[i] && !b[i]) begin
                    if (MSB_INV && (i == WIDTH - 1)) begin
                        lt_c = 1'b1;
                    end else begin
                        gt_c = 1'b1;
                    end
                    eq_c = 1'b0;
                end else if (!a[i] && b[i]) begin
                    if (MSB_INV && (i == WIDTH - 1)) begin
                        gt_c = 1'b1;
                    end else begin
                        lt_c = 1'b1;
                    end
                    eq_c = 1'b0;
                end
            end
        end
    end

    // Capture the cascade result on accepted inputs; out_valid is a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            x         <= 1'b0;
            y         <= 1'b0;
            z         <= 1'b0;
        end else if (in_valid) begin
            out_valid <= 1'b1;
            x         <= gt_c;
            y         <= eq_c;
            z         <= lt_c;
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_magnitude_comparator.sv
// Directed and exhaustive bench for magnitude_comparator at WIDTH=4.
// Expectations follow the build selected by COMPARATOR_SIGNED_EN.
module tb_magnitude_comparator;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       x;
    logic       y;
    logic       z;

    int errs;
    int checks;

    magnitude_comparator #(.WIDTH(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .x        (x),
        .y        (y),
        .z        (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: {gt, eq, lt} from integer comparison.
    function automatic logic [2:0] ref_cmp(input logic [3:0] ra,
                                           input logic [3:0] rb);
`ifdef COMPARATOR_SIGNED_EN
        if ($signed(ra) > $signed(rb)) return 3'b100;
        if ($signed(ra) < $signed(rb)) return 3'b001;
`else
        if (ra > rb) return 3'b100;
        if (ra < rb) return 3'b001;
`endif
        return 3'b010;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] outs;
        return {out_valid, x, y, z};
    endfunction

    logic [3:0] va [4];
    logic [3:0] vb [4];
    logic [2:0] ve [4];

    initial begin
        errs     = 0;
        checks   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'b0111;
        b        = 4'b0001;

        tick();
        check("reset_c1", 32'(outs()), 32'h0);
        tick();
        check("reset_c2", 32'(outs()), 32'h0);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("idle_zero", 32'(outs()), 32'h0);

        va[0] = 4'b0011; vb[0] = 4'b1000;
        va[1] = 4'b0111; vb[1] = 4'b0001;
        va[2] = 4'b1001; vb[2] = 4'b1001;
        va[3] = 4'b1011; vb[3] = 4'b1111;
`ifdef COMPARATOR_SIGNED_EN
        ve[0] = 3'b100; ve[1] = 3'b100; ve[2] = 3'b010; ve[3] = 3'b001;
`else
        ve[0] = 3'b001; ve[1] = 3'b100; ve[2] = 3'b010; ve[3] = 3'b001;
`endif
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            a = va[i];
            b = vb[i];
            tick();
            check($sformatf("dir%0d", i), 32'(outs()), 32'({1'b1, ve[i]}));
        end

        a = 4'b0000; b = 4'b1111;
        tick();
`ifdef COMPARATOR_SIGNED_EN
        check("bnd_0_vs_f", 32'(outs()), 32'b1100);
`else
        check("bnd_0_vs_f", 32'(outs()), 32'b1001);
`endif
        a = 4'b1111; b = 4'b0000;
        tick();
`ifdef COMPARATOR_SIGNED_EN
        check("bnd_f_vs_0", 32'(outs()), 32'b1001);
`else
        check("bnd_f_vs_0", 32'(outs()), 32'b1100);
`endif
        a = 4'b0000; b = 4'b0000;
        tick();
        check("bnd_0_vs_0", 32'(outs()), 32'b1010);

        a = 4'b0111; b = 4'b0001;
        tick();
        check("hold_load", 32'(outs()), 32'b1100);
        in_valid = 1'b0;
        a = 4'b0000; b = 4'b1111;
        tick();
        check("hold_c1", 32'(outs()), 32'b0100);
        a = 4'b1001; b = 4'b1001;
        tick();
        check("hold_c2", 32'(outs()), 32'b0100);

        rst_n    = 1'b0;
        in_valid = 1'b1;
        a = 4'b0000; b = 4'b1111;
        tick();
        check("mid_reset", 32'(outs()), 32'h0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tick();
        check("no_stale_c1", 32'(outs()), 32'h0);
        tick();
        check("no_stale_c2", 32'(outs()), 32'h0);

        in_valid = 1'b1;
        for (int i = 0; i < 256; i++) begin
            a = 4'(i >> 4);
            b = 4'(i);
            tick();
            check($sformatf("exh_%h_%h", a, b), 32'(outs()),
                  32'({1'b1, ref_cmp(a, b)}));
            check($sformatf("onehot_%h_%h", a, b),
                  32'(int'(x) + int'(y) + int'(z)), 32'd1);
        end
        in_valid = 1'b0;
        tick();
        check("final_pulse_end", 32'(out_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/magnitude_comparator.md
# magnitude_comparator

Registered magnitude comparator for two unsigned WIDTH-bit operands, producing one-hot greater, equal and less flags. Used in the combinational-circuit datapath wherever two small operands are ranked, e.g. threshold checks and sort/select stages. The compare logic is an MSB-first cascade of per-bit compare cells. Results are registered once, with a valid flag travelling alongside.

## Interface
Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge system clock.
- rst_n  input  1  reset, synchronous and active-low.
- in_valid  input  1  a/b are sampled on this edge.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- out_valid  output  1  x/y/z hold a fresh result.
- x  output  1  A > B.
- y  output  1  A == B.
- z  output  1  A < B.

## Operation
- Cascade runs MSB to LSB. Each bit cell takes the upstream (gt, eq, lt) and bits a[i], b[i]:
  - if upstream gt or lt is set, pass it through unchanged;
  - else if a[i] > b[i], set gt;
  - else if a[i] < b[i], set lt;
  - else keep eq.
- Cascade seed at the MSB is (gt=0, eq=1, lt=0).
- Final cascade output feeds the x/y/z registers.
- When out_valid=1, exactly one of x, y, z is 1.
- Comparison is unsigned by default; a=0 and b=2^WIDTH-1 gives z=1.
- No arithmetic subtraction is used, so no carry or overflow exists at any width.
- in_valid=0: x, y, z and out_valid hold their previous values. Exception: out_valid clears to 0 on the first such edge, so it is a one-cycle pulse per accepted input.
- There is no backpressure; every in_valid=1 cycle is accepted.

## Timing
- Latency: 1 cycle. Operands sampled at edge N give results visible after edge N.
- Throughput: one comparison per cycle; back-to-back in_valid is supported.
- Reset: rst_n=0 at a rising edge gives x=0, y=0, z=0 and out_valid=0 after that edge.
- in_valid is ignored during a reset cycle. No result from the reset cycle appears later.
- Reset mid-stream drops the pending result. The first valid result after release appears one cycle after the first in_valid=1 edge with rst_n=1.
- Between valid results, x/y/z are stable. Before the first valid result after reset they are all 0, which is the only legal all-zero state.

## Configuration
- Macro COMPARATOR_SIGNED_EN.
- Defined:
  - operands are two's complement;
  - the MSB cell inverts its sense: a[MSB]=1, b[MSB]=0 means A < B;
  - lower bits are compared unsigned as normal.
- Undefined: pure unsigned comparison as described above.
- Port list, latency and reset behaviour are identical in both builds.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, a=4'b0111, b=4'b0001 -> x=y=z=0, out_valid=0 throughout.
- Unsigned directed, WIDTH=4, one vector per cycle:
  - 0011 vs 1000 -> z=1
  - 0111 vs 0001 -> x=1
  - 1001 vs 1001 -> y=1
  - 1011 vs 1111 -> z=1
  - each result one cycle after its input, out_valid=1 each cycle.
- Signed build (COMPARATOR_SIGNED_EN), same four vectors -> x=1, x=1, y=1, z=1 respectively.
- Boundaries, unsigned:
  - 0000 vs 1111 -> z=1
  - 1111 vs 0000 -> x=1
  - 0000 vs 0000 -> y=1
- Hold behaviour: valid 0111 vs 0001, then in_valid=0 while a/b change -> x stays 1, out_valid 1 for exactly one cycle. Then assert rst_n=0 mid-stream with a valid input -> all outputs 0 next cycle, no stale result afterwards.
- Exhaustive: all 256 a/b pairs at WIDTH=4 in both builds, against a reference model -> exactly one flag set, correct per pair.
